hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage MIPS core.
- Sits beside the ID stage and drives the stall, flush and bubble enables for the PC, IF/ID and ID/EX registers.
- Detects load-use and branch-operand data hazards against EX/MEM.
- Owns the occupancy FSM of the multi-cycle mult/div unit.
- Qualifies the ID-stage branch decision (In_PCSrc) into an IF/ID flush.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/md_occupancy.sv | 58 +++++
 rtl/hazard_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MD_LATENCY_DEF = 8;

    // Wide enough for the largest legal MD_LATENCY (31).
    localparam int unsigned MD_CNT_W = 5;

    // A producer only matters if it writes a real register.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/md_occupancy.sv
// Occupancy FSM and down-counter for the multi-cycle mult/div unit.
module md_occupancy
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic issue,
    output logic busy,
    output logic start
);

    localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LATENCY - 1);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (issue) begin
                    state_d = MD_BUSY;
                    cnt_d   = LOAD_VAL;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy  = (state_q == MD_BUSY);
        start = (state_q == MD_IDLE) && issue && Rst_n;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bubble sequencing for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_CNT_EN to build the stall-cycle performance counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       In_IDRs,
    input  logic [4:0]       In_IDRt,
    input  logic             In_IDUsesRt,
    input  logic             In_IDBranch,
    input  logic             In_IDMulDiv,
    input  logic             In_IDUsesHiLo,
    input  logic             In_PCSrc,
    input  logic [4:0]       In_EXRd,
    input  logic             In_EXRegWrite,
    input  logic             In_EXMemRead,
    input  logic [4:0]       In_MEMRd,
    input  logic             In_MEMMemRead,
    output logic             OutPCWrite,
    output logic             OutIFIDWrite,
    output logic             OutIFIDFlush,
    output logic             OutIDEXBubble,
    output logic             OutMDBusy,
    output logic             OutMDStart,
    output logic [CNT_W-1:0] OutStallCycles
);

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic load_use, br_alu, br_load;
    logic data_haz, md_haz, stall;
    logic md_issue, md_busy, md_start;

    always_comb begin
        ex_rs    = reg_match(In_EXRd, In_IDRs);
        ex_rt    = reg_match(In_EXRd, In_IDRt);
        mem_rs   = reg_match(In_MEMRd, In_IDRs);
        mem_rt   = reg_match(In_MEMRd, In_IDRt);
        load_use = In_EXMemRead && (ex_rs || (ex_rt && In_IDUsesRt));
        // Branches compare in ID, so they also wait on ALU results and loads in MEM.
        br_alu   = In_IDBranch && In_EXRegWrite && (ex_rs || ex_rt);
        br_load  = In_IDBranch && In_MEMMemRead && (mem_rs || mem_rt);
        data_haz = load_use || br_alu || br_load;
        md_haz   = md_busy && (In_IDMulDiv || In_IDUsesHiLo);
        stall    = data_haz || md_haz;
        md_issue = In_IDMulDiv && !stall;
    end

    md_occupancy #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_occupancy (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .issue(md_issue),
        .busy (md_busy),
        .start(md_start)
    );

    always_comb begin
        OutPCWrite    = !stall;
        OutIFIDWrite  = !stall;
        OutIDEXBubble = stall;
        OutIFIDFlush  = In_PCSrc && !stall;
        OutMDBusy     = md_busy;
        OutMDStart    = md_start;
        // Hold the pipeline frozen and cleared while reset is asserted.
        if (!Rst_n) begin
            OutPCWrite    = 1'b0;
            OutIFIDWrite  = 1'b0;
            OutIFIDFlush  = 1'b1;
            OutIDEXBubble = 1'b1;
            OutMDBusy     = 1'b0;
            OutMDStart    = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign OutStallCycles = stall_cnt_q;
`else
    assign OutStallCycles = '0;
`endif

endmodule
